// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_BUSY,
    ST_FULL
  } skid_state_t;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage : pipe_pkg

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule : sat_counter

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready handshake, 2-entry skid buffer, synchronous flush.
// Optional stall/flush statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               NBITS     = 32,
  parameter int               IBITS     = 32,
  parameter logic [IBITS-1:0] NOP_INSTR = IBITS'(MIPS_NOP),
  parameter int               CNT_BITS  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NBITS-1:0]    i_pc,
  input  logic [IBITS-1:0]    i_instruction,
  input  logic                i_hazard_detected,
  input  logic                i_ready,
  input  logic                i_flush,
  output logic                o_valid,
  output logic [NBITS-1:0]    o_pc,
  output logic [IBITS-1:0]    o_instruction
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_BITS-1:0] o_stall_cnt,
  output logic [CNT_BITS-1:0] o_flush_cnt
`endif
);

  skid_state_t      state_reg, state_next;
  logic [NBITS-1:0] main_pc_reg, main_pc_next;
  logic [IBITS-1:0] main_instr_reg, main_instr_next;
  logic [NBITS-1:0] skid_pc_reg, skid_pc_next;
  logic [IBITS-1:0] skid_instr_reg, skid_instr_next;
  logic             ready_reg, ready_next;

  logic dn_ready;
  logic accept;

  assign dn_ready = i_ready & ~i_hazard_detected;
  assign accept   = i_valid & ready_reg;

  always_comb begin
    state_next      = state_reg;
    main_pc_next    = main_pc_reg;
    main_instr_next = main_instr_reg;
    skid_pc_next    = skid_pc_reg;
    skid_instr_next = skid_instr_reg;

    if (i_flush) begin
      state_next      = ST_EMPTY;
      main_pc_next    = '0;
      main_instr_next = NOP_INSTR;
      skid_pc_next    = '0;
      skid_instr_next = NOP_INSTR;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next      = ST_BUSY;
            main_pc_next    = i_pc;
            main_instr_next = i_instruction;
          end
        end
        ST_BUSY: begin
          if (accept && dn_ready) begin
            main_pc_next    = i_pc;
            main_instr_next = i_instruction;
          end else if (accept) begin
            // Downstream stalled: park the new entry, keep the output stable.
            state_next      = ST_FULL;
            skid_pc_next    = i_pc;
            skid_instr_next = i_instruction;
          end else if (dn_ready) begin
            // Drained with nothing behind it: emit a bubble, PC left as-is.
            state_next      = ST_EMPTY;
            main_instr_next = NOP_INSTR;
          end
        end
        ST_FULL: begin
          if (dn_ready) begin
            state_next      = ST_BUSY;
            main_pc_next    = skid_pc_reg;
            main_instr_next = skid_instr_reg;
            skid_pc_next    = '0;
            skid_instr_next = NOP_INSTR;
          end
        end
        default: begin
          state_next      = ST_EMPTY;
          main_pc_next    = '0;
          main_instr_next = NOP_INSTR;
          skid_pc_next    = '0;
          skid_instr_next = NOP_INSTR;
        end
      endcase
    end

    // Ready is a flop so upstream never sees a combinational path from i_ready.
    ready_next = (state_next != ST_FULL);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_EMPTY;
      main_pc_reg    <= '0;
      main_instr_reg <= NOP_INSTR;
      skid_pc_reg    <= '0;
      skid_instr_reg <= NOP_INSTR;
      ready_reg      <= 1'b1;
    end else begin
      state_reg      <= state_next;
      main_pc_reg    <= main_pc_next;
      main_instr_reg <= main_instr_next;
      skid_pc_reg    <= skid_pc_next;
      skid_instr_reg <= skid_instr_next;
      ready_reg      <= ready_next;
    end
  end

  assign o_valid       = (state_reg != ST_EMPTY);
  assign o_ready       = ready_reg;
  assign o_pc          = main_pc_reg;
  assign o_instruction = main_instr_reg;

`ifdef PIPE_STAGE_STATS_EN
  sat_counter #(.W(CNT_BITS)) u_stall_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (o_valid & ~dn_ready),
    .count (o_stall_cnt)
  );

  sat_counter #(.W(CNT_BITS)) u_flush_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (i_flush),
    .count (o_flush_cnt)
  );
`endif

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboarded checks for pipe_stage_skid; stats checks run when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_skid;

  localparam int          NBITS    = 32;
  localparam int          IBITS    = 32;
  localparam int          CNT_BITS = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic             clk;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic [NBITS-1:0] i_pc;
  logic [IBITS-1:0] i_instruction;
  logic             i_hazard_detected;
  logic             i_ready;
  logic             i_flush;
  logic             o_valid;
  logic [NBITS-1:0] o_pc;
  logic [IBITS-1:0] o_instruction;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_BITS-1:0] o_stall_cnt;
  logic [CNT_BITS-1:0] o_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  pipe_stage_skid #(
    .NBITS    (NBITS),
    .IBITS    (IBITS),
    .NOP_INSTR(NOP),
    .CNT_BITS (CNT_BITS)
  ) dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .i_pc              (i_pc),
    .i_instruction     (i_instruction),
    .i_hazard_detected (i_hazard_detected),
    .i_ready           (i_ready),
    .i_flush           (i_flush),
    .o_valid           (o_valid),
    .o_pc              (o_pc),
    .o_instruction     (o_instruction)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .o_stall_cnt       (o_stall_cnt),
    .o_flush_cnt       (o_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic haz, input logic fl);
    i_valid           = v;
    i_pc              = pc;
    i_instruction     = instr_of(pc);
    i_ready           = rdy;
    i_hazard_detected = haz;
    i_flush           = fl;
  endtask

  task automatic show(input string what);
    $display("txn %-10s o_valid=%0b o_pc=%h o_instr=%h o_ready=%0b",
             what, o_valid, o_pc, o_instruction, o_ready);
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    do_reset();
    show("reset");
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_pc",    o_pc, 32'h0);
    check("rst_instr", o_instruction, NOP);
    check("rst_ready", 32'(o_ready), 32'd1);

    // 1: streaming at full rate, one cycle latency
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(k * 4), 1'b1, 1'b0, 1'b0);
      step();
      show("stream");
      check("t1_valid", 32'(o_valid), 32'd1);
      check("t1_pc",    o_pc, 32'(k * 4));
      check("t1_instr", o_instruction, instr_of(32'(k * 4)));
      check("t1_ready", 32'(o_ready), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    show("drain");
    check("t1_bubble_valid", 32'(o_valid), 32'd0);
    check("t1_bubble_instr", o_instruction, NOP);
    check("t1_bubble_pc",    o_pc, 32'h8);

    // 2: one-cycle backpressure fills the skid, release drains it
    drive(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
    step();
    check("t2_busy_pc", o_pc, 32'h10);
    drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
    step();
    show("full");
    check("t2_full_ready", 32'(o_ready), 32'd0);
    check("t2_full_pc",    o_pc, 32'h10);
    check("t2_full_valid", 32'(o_valid), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    show("release");
    check("t2_rel_pc",    o_pc, 32'h14);
    check("t2_rel_instr", o_instruction, instr_of(32'h14));
    check("t2_rel_ready", 32'(o_ready), 32'd1);
    step();
    check("t2_empty_valid", 32'(o_valid), 32'd0);

    // 3: flush while FULL with a same-cycle upstream entry
    drive(1'b1, 32'h18, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h1C, 1'b0, 1'b0, 1'b0);
    step();
    check("t3_full_ready", 32'(o_ready), 32'd0);
    drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
    step();
    show("flush");
    check("t3_fl_valid", 32'(o_valid), 32'd0);
    check("t3_fl_instr", o_instruction, NOP);
    check("t3_fl_pc",    o_pc, 32'h0);
    check("t3_fl_ready", 32'(o_ready), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    check("t3_post_valid", 32'(o_valid), 32'd0);
    check("t3_post_pc",    o_pc, 32'h0);

    // 4: hazard stall holds the output
    do_reset();
    drive(1'b1, 32'h30, 1'b1, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      step();
      show("hazard");
      check("t4_valid", 32'(o_valid), 32'd1);
      check("t4_pc",    o_pc, 32'h30);
      check("t4_instr", o_instruction, instr_of(32'h30));
    end
`ifdef PIPE_STAGE_STATS_EN
    check("t4_stall_cnt", 32'(o_stall_cnt), 32'd3);
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    check("t4_drain_valid", 32'(o_valid), 32'd0);

    // 5: random traffic against a FIFO scoreboard
    for (int c = 0; c < 10000; c++) begin
      i_valid           = 1'($urandom_range(0, 1));
      i_pc              = $urandom;
      i_instruction     = $urandom;
      i_ready           = ($urandom_range(0, 3) != 0);
      i_hazard_detected = ($urandom_range(0, 7) == 0);
      i_flush           = 1'b0;
      if (!o_valid) check("t5_nop", o_instruction, NOP);
      if (o_valid && i_ready && !i_hazard_detected) begin
        if (sb.size() == 0) begin
          check("t5_sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          check("t5_pc",    o_pc, e[63:32]);
          check("t5_instr", o_instruction, e[31:0]);
        end
      end
      if (i_valid && o_ready) sb.push_back({i_pc, i_instruction});
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (o_valid) begin
        if (sb.size() == 0) begin
          check("t5_sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          check("t5_drain_pc",    o_pc, e[63:32]);
          check("t5_drain_instr", o_instruction, e[31:0]);
        end
      end
      step();
    end
    $display("txn random   done, %0d entries left in scoreboard", sb.size());
    check("t5_sb_empty",    32'(sb.size()), 32'd0);
    check("t5_final_valid", 32'(o_valid), 32'd0);

`ifdef PIPE_STAGE_STATS_EN
    // 6: flush counter saturates, reset clears both counters
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    show("flush x20");
    check("t6_flush_sat", 32'(o_flush_cnt), 32'hF);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("t6_rst_flush", 32'(o_flush_cnt), 32'd0);
    check("t6_rst_stall", 32'(o_stall_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_stage_skid
